// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: op codes, FSM encoding, widths.
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int ALU_OPW   = 3;

  // ALU op codes understood by the shared ALU; other codes pass through untouched
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_BEQ = 3'b011;

  // Sequencer FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_arbiter_rr_pick2.sv
// Two-way round-robin selector: a lone requester wins outright, a tie goes
// to the requester that did not win last time.
module rr_pick2 (
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_last_grant,
  output logic o_grant_valid,
  output logic o_grant_id
);

  // Pick the winner from the current valids and the previous grant
  always_comb begin
    o_grant_valid = i_valid0 | i_valid1;
    if (i_valid0 && i_valid1) begin
      o_grant_id = ~i_last_grant;
    end else begin
      o_grant_id = i_valid1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer sharing one combinational ALU between
// two requesters: accept in IDLE, drive ALU from registers in EXEC, hold the
// captured result on the owner's response channel in RESP.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int OPW   = ALU_OPW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [OPW-1:0]   r_alu_op;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_owner;
  logic             r_last_grant;

  logic             w_grant_valid;
  logic             w_grant_id;
  logic             w_idle;
  logic             w_in_resp;
  logic             w_accept;
  logic             w_rsp_ready;
  logic             w_rsp_done;
  logic [OPW-1:0]   w_sel_op;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;

  rr_pick2 u_pick (
    .i_valid0      (req0_valid),
    .i_valid1      (req1_valid),
    .i_last_grant  (r_last_grant),
    .o_grant_valid (w_grant_valid),
    .o_grant_id    (w_grant_id)
  );

  assign w_idle    = (r_state == ST_IDLE);
  assign w_in_resp = (r_state == ST_RESP);

  // The winner's valid is high by construction, so any grant in IDLE is a handshake
  assign w_accept   = w_idle & w_grant_valid;
  assign req0_ready = w_accept & ~w_grant_id;
  assign req1_ready = w_accept &  w_grant_id;

  assign rsp0_valid  = w_in_resp & ~r_owner;
  assign rsp1_valid  = w_in_resp &  r_owner;
  assign rsp0_result = r_result;
  assign rsp1_result = r_result;
  assign rsp0_zero   = r_zero;
  assign rsp1_zero   = r_zero;

  assign w_rsp_ready = r_owner ? rsp1_ready : rsp0_ready;
  assign w_rsp_done  = w_in_resp & w_rsp_ready;

  assign alu_op = r_alu_op;
  assign alu_a  = r_alu_a;
  assign alu_b  = r_alu_b;

  // Route the winning requester's operation toward the ALU drive registers
  always_comb begin
    if (w_grant_id) begin
      w_sel_op = req1_op;
      w_sel_a  = req1_a;
      w_sel_b  = req1_b;
    end else begin
      w_sel_op = req0_op;
      w_sel_a  = req0_a;
      w_sel_b  = req0_b;
    end
  end

  // Next-state logic: EXEC lasts one cycle, RESP waits for the owner's ready
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_EXEC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EXEC: w_state_nxt = ST_RESP;
      ST_RESP: begin
        if (w_rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, ALU drive, capture and round-robin history registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_alu_op     <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_result     <= '0;
      r_zero       <= 1'b0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_alu_op <= w_sel_op;
        r_alu_a  <= w_sel_a;
        r_alu_b  <= w_sel_b;
        r_owner  <= w_grant_id;
      end
      if (r_state == ST_EXEC) begin
        r_result <= alu_result;
        r_zero   <= alu_zero;
      end
      if (w_rsp_done) begin
        r_last_grant <= r_owner;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a transaction-level model (busy flag, countdown to
// response, round-robin history) predicts every output each cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op = 3'd0, req1_op = 3'd0;
  logic [31:0] req0_a = 32'd0, req0_b = 32'd0, req1_a = 32'd0, req1_b = 32'd0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_zero, rsp1_zero;
  logic [2:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_zero;

  int n_cmp = 0;
  int n_bad = 0;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;

  // Shared ALU behaviour: {zero, result}
  function automatic logic [32:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      3'd0:    r = a + b;
      3'd1:    r = a - b;
      3'd2:    r = a | b;
      3'd3:    r = a - b;
      default: r = 32'd0;
    endcase
    return {(r == 32'd0), r};
  endfunction

  always_comb {alu_zero, alu_result} = alu_fn(alu_op, alu_a, alu_b);

  // ---------------- transaction-level model ----------------
  bit          m_busy;
  int          m_wait;
  bit          m_owner;
  bit          m_last;
  logic [31:0] m_res;
  logic        m_zero;
  logic [2:0]  m_op;
  logic [31:0] m_a, m_b;
  int          grants[$];

  task automatic model_reset();
    m_busy = 0; m_wait = 0; m_owner = 0; m_last = 1;
    m_res = 32'd0; m_zero = 1'b0; m_op = 3'd0; m_a = 32'd0; m_b = 32'd0;
  endtask

  function automatic bit win_valid();
    return !m_busy && (req0_valid || req1_valid);
  endfunction

  function automatic bit win_id();
    if (req0_valid && req1_valid) return !m_last;
    return req1_valid;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model for the current cycle
  task automatic compare_model();
    bit rv;
    rv = m_busy && (m_wait == 0);
    chk1("req0_ready", req0_ready, win_valid() && !win_id());
    chk1("req1_ready", req1_ready, win_valid() &&  win_id());
    chk1("rsp0_valid", rsp0_valid, rv && !m_owner);
    chk1("rsp1_valid", rsp1_valid, rv &&  m_owner);
    chk32("alu_op", {29'd0, alu_op}, {29'd0, m_op});
    chk32("alu_a", alu_a, m_a);
    chk32("alu_b", alu_b, m_b);
    if (rv && !m_owner) begin
      chk32("rsp0_result", rsp0_result, m_res);
      chk1("rsp0_zero", rsp0_zero, m_zero);
    end
    if (rv && m_owner) begin
      chk32("rsp1_result", rsp1_result, m_res);
      chk1("rsp1_zero", rsp1_zero, m_zero);
    end
  endtask

  // Advance the model across one rising edge using the inputs held there
  task automatic model_step();
    if (rst) begin
      model_reset();
    end else if (!m_busy) begin
      if (win_valid()) begin
        m_busy = 1; m_wait = 1; m_owner = win_id();
        grants.push_back(int'(m_owner));
        if (m_owner) begin m_op = req1_op; m_a = req1_a; m_b = req1_b; end
        else         begin m_op = req0_op; m_a = req0_a; m_b = req0_b; end
      end
    end else if (m_wait > 0) begin
      m_wait = 0;
      {m_zero, m_res} = alu_fn(m_op, m_a, m_b);
    end else if (m_owner ? rsp1_ready : rsp0_ready) begin
      m_busy = 0; m_last = m_owner;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    compare_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin settle(); tick(); end
  endtask

  task automatic set_req0(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
  endtask

  task automatic set_req1(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
  endtask

  initial begin
    model_reset();
    // reset: let registers initialise, then check reset values while held
    tick(); tick();
    settle();
    chk32("rst_alu_a", alu_a, 32'd0);
    chk32("rst_alu_op", {29'd0, alu_op}, 32'd0);
    chk1("rst_rsp0_valid", rsp0_valid, 1'b0);
    tick();
    rst = 1'b0;

    // single ADD from requester 0
    set_req0(1'b1, 3'b000, 32'd5, 32'd7); rsp0_ready = 1'b1;
    settle(); chk1("t1_ready0", req0_ready, 1'b1); tick();
    req0_valid = 1'b0;
    settle(); chk32("t1_alu_a", alu_a, 32'd5); tick();
    settle();
    chk1("t1_rsp0_valid", rsp0_valid, 1'b1);
    chk32("t1_result", rsp0_result, 32'd12);
    chk1("t1_zero", rsp0_zero, 1'b0);
    tick();
    step(1);

    // compare-equal from requester 1
    set_req1(1'b1, 3'b011, 32'h1234, 32'h1234); rsp1_ready = 1'b1;
    settle(); chk1("t2_ready1", req1_ready, 1'b1); tick();
    req1_valid = 1'b0;
    step(1);
    settle();
    chk1("t2_rsp1_valid", rsp1_valid, 1'b1);
    chk32("t2_result", rsp1_result, 32'd0);
    chk1("t2_zero", rsp1_zero, 1'b1);
    chk1("t2_rsp0_valid", rsp0_valid, 1'b0);
    tick();

    // contention: grants alternate starting with requester 0
    set_req0(1'b1, 3'b010, 32'hF0, 32'h0F);
    set_req1(1'b1, 3'b000, 32'd100, 32'd23);
    grants.delete();
    for (int i = 0; i < 12; i++) begin
      settle();
      if (i % 6 == 2) begin
        chk1("t3_rsp0_valid", rsp0_valid, 1'b1);
        chk32("t3_or_result", rsp0_result, 32'hFF);
      end
      if (i % 6 == 5) begin
        chk1("t3_rsp1_valid", rsp1_valid, 1'b1);
        chk32("t3_add_result", rsp1_result, 32'd123);
      end
      tick();
    end
    n_cmp++;
    if (grants.size() != 4 || grants[0] != 0 || grants[1] != 1 || grants[2] != 0 || grants[3] != 1) begin
      n_bad++;
      $display("FAIL t3_grant_order: got %p expected '{0,1,0,1}", grants);
    end

    // backpressure on requester 0 while requester 1 waits
    rst = 1'b1; tick(); rst = 1'b0;
    set_req0(1'b1, 3'b001, 32'd50, 32'd8);
    set_req1(1'b1, 3'b000, 32'd1, 32'd1);
    rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    settle(); chk1("t4_ready0", req0_ready, 1'b1); tick();
    step(1);
    for (int i = 0; i < 5; i++) begin
      settle();
      chk1("t4_hold_valid", rsp0_valid, 1'b1);
      chk32("t4_hold_result", rsp0_result, 32'd42);
      chk1("t4_ready1_blocked", req1_ready, 1'b0);
      tick();
    end
    rsp0_ready = 1'b1;
    settle(); chk1("t4_release_valid", rsp0_valid, 1'b1); tick();
    settle(); chk1("t4_ready1_next", req1_ready, 1'b1); tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step(4);

    // reset during EXEC discards the SUB
    set_req0(1'b1, 3'b001, 32'd10, 32'd3);
    settle(); tick();
    req0_valid = 1'b0; rst = 1'b1;
    settle(); chk32("t5_exec_alu_a", alu_a, 32'd10); tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk1("t5_no_rsp0", rsp0_valid, 1'b0);
      chk1("t5_no_rsp1", rsp1_valid, 1'b0);
      tick();
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    settle();
    chk1("t5_first_grant0", req0_ready, 1'b1);
    chk1("t5_first_grant1", req1_ready, 1'b0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step(3);

    // undefined op passes through
    set_req0(1'b1, 3'b111, 32'd1, 32'd1); rsp0_ready = 1'b1;
    settle(); tick();
    req0_valid = 1'b0;
    step(1);
    settle();
    chk1("t6_rsp0_valid", rsp0_valid, 1'b1);
    chk32("t6_result", rsp0_result, 32'd0);
    chk1("t6_zero", rsp0_zero, 1'b1);
    tick();
    settle(); chk1("t6_done", rsp0_valid, 1'b0); tick();

    // randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      set_req0(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(), $urandom());
      set_req1(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(), $urandom());
      if (i % 7 == 0) begin
        req1_b = req1_a;
        req0_b = req0_a;
      end
      rsp0_ready = 1'($urandom_range(0, 1));
      rsp1_ready = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 199) == 0);
      settle();
      tick();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
